// File: rtl/soc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : soc_pkg
//  Description : Shared register offsets and bit positions for the timer
//                peripheral on the 6502 SoC page decode.
//  Revision    : 1.0  initial release
// ============================================================================
package soc_pkg;

  // Register offsets selected by CPU_AB[1:0]
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CNTL = 2'd2;
  localparam logic [1:0] REG_CNTH = 2'd3;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

  // STATUS bit positions
  localparam int STAT_TF  = 0;
  localparam int STAT_RUN = 7;

endpackage
`default_nettype wire

// File: rtl/timer_6502_if.sv
`default_nettype none
// ============================================================================
//  Module      : timer_6502_if
//  Description : CPU-side register bus for the interval timer. The CPU is the
//                master; the timer is the slave driving read data and IRQ.
//  Revision    : 1.0  initial release
// ============================================================================
interface timer_6502_if;

  logic       cs;
  logic       we;
  logic [1:0] rs;
  logic [7:0] din;
  logic [7:0] dout;
  logic       irq;

  modport master (
    output cs,
    output we,
    output rs,
    output din,
    input  dout,
    input  irq
  );

  modport slave (
    input  cs,
    input  we,
    input  rs,
    input  din,
    output dout,
    output irq
  );

endinterface
`default_nettype wire

// File: rtl/timer_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : timer_prescaler
//  Description : Divide-by-PRESCALE counter with enable and synchronous clear.
//                tick_o is high for the one cycle in which the counter wraps.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_prescaler #(
  parameter int PRESCALE = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  // A one-bit counter pinned at zero covers PRESCALE=1: every enabled cycle ticks.
  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  // Prescale counter: clear has priority, holds while disabled, wraps at LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i & (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/timer_6502.sv
`default_nettype none
// ============================================================================
//  Module      : timer_6502
//  Description : Memory-mapped 16-bit interval timer for the 6502 SoC with
//                periodic / one-shot modes, coherent 16-bit count snapshot
//                and a level IRQ (TF & IE) derived only from registers.
//  Revision    : 1.0  initial release
// ============================================================================
module timer_6502
  import soc_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic         clk,
  input  logic         rst,
  timer_6502_if.slave  bus
);

  logic        en_q, en_d;
  logic        ie_q, ie_d;
  logic        oneshot_q, oneshot_d;
  logic        tf_q, tf_d;
  logic [15:0] reload_q, reload_d;
  logic [15:0] count_q, count_d;
  logic [7:0]  hi_latch_q, hi_latch_d;
  logic [7:0]  dout_q, dout_d;

  logic w_wr;
  logic w_rd;
  logic w_ctrl_wr;
  logic w_stat_wr;
  logic w_rlo_wr;
  logic w_rhi_wr;
  logic w_tick;
  logic w_terminal;
  logic w_en_set;
  logic w_oneshot_eff;

  assign w_wr      = bus.cs &  bus.we;
  assign w_rd      = bus.cs & ~bus.we;
  assign w_ctrl_wr = w_wr & (bus.rs == REG_CTRL);
  assign w_stat_wr = w_wr & (bus.rs == REG_STAT);
  assign w_rlo_wr  = w_wr & (bus.rs == REG_CNTL);
  assign w_rhi_wr  = w_wr & (bus.rs == REG_CNTH);

  // Only a 0->1 transition of EN restarts the count; rewriting EN=1 is benign.
  assign w_en_set = w_ctrl_wr & bus.din[CTRL_EN] & ~en_q;

  // A CTRL write landing on the terminal tick decides the ONESHOT behaviour.
  assign w_oneshot_eff = w_ctrl_wr ? bus.din[CTRL_ONESHOT] : oneshot_q;

  assign w_terminal = w_tick & (count_q == 16'h0000);

  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en_i   (en_q),
    .clr_i  (w_en_set),
    .tick_o (w_tick)
  );

  // Next-state logic for control, count, flag, reload and the read data path.
  always_comb begin
    en_d       = en_q;
    ie_d       = ie_q;
    oneshot_d  = oneshot_q;
    tf_d       = tf_q;
    reload_d   = reload_q;
    count_d    = count_q;
    hi_latch_d = hi_latch_q;
    dout_d     = dout_q;

    // CPU write to EN beats the one-shot auto-disable on the same edge.
    if (w_ctrl_wr) begin
      en_d      = bus.din[CTRL_EN];
      ie_d      = bus.din[CTRL_IE];
      oneshot_d = bus.din[CTRL_ONESHOT];
    end else if (w_terminal && w_oneshot_eff) begin
      en_d = 1'b0;
    end

    // Ticks only occur while en_q=1, so they never coincide with w_en_set.
    if (w_en_set) begin
      count_d = reload_q;
    end else if (w_tick) begin
      if (count_q == 16'h0000) begin
        count_d = w_oneshot_eff ? 16'h0000 : reload_q;
      end else begin
        count_d = count_q - 16'd1;
      end
    end

    // Timeout set beats a simultaneous write-one-to-clear.
    if (w_terminal) begin
      tf_d = 1'b1;
    end else if (w_stat_wr && bus.din[STAT_TF]) begin
      tf_d = 1'b0;
    end

    if (w_rlo_wr) begin
      reload_d[7:0] = bus.din;
    end
    if (w_rhi_wr) begin
      reload_d[15:8] = bus.din;
    end

    if (w_rd) begin
      unique case (bus.rs)
        REG_CTRL: dout_d = {5'b0, oneshot_q, ie_q, en_q};
        REG_STAT: dout_d = {en_q, 6'b0, tf_q};
        REG_CNTL: dout_d = count_q[7:0];
        REG_CNTH: dout_d = hi_latch_q;
        default:  dout_d = 8'h00;
      endcase
      // Low-byte read freezes the high byte so a later CNTH read is coherent.
      if (bus.rs == REG_CNTL) begin
        hi_latch_d = count_q[15:8];
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      oneshot_q  <= 1'b0;
      tf_q       <= 1'b0;
      reload_q   <= 16'hFFFF;
      count_q    <= 16'h0000;
      hi_latch_q <= 8'h00;
      dout_q     <= 8'h00;
    end else begin
      en_q       <= en_d;
      ie_q       <= ie_d;
      oneshot_q  <= oneshot_d;
      tf_q       <= tf_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      hi_latch_q <= hi_latch_d;
      dout_q     <= dout_d;
    end
  end

  assign bus.dout = dout_q;
  assign bus.irq  = tf_q & ie_q;

endmodule
`default_nettype wire

// File: tb/tb_timer_6502.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_6502
//  Description : Directed self-checking bench for timer_6502 (PRESCALE=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timer_6502;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  timer_6502_if bus_if ();

  timer_6502 #(
    .PRESCALE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
      else begin
        errors++;
        $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp_v);
      end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    bus_if.cs  = 1'b1;
    bus_if.we  = 1'b1;
    bus_if.rs  = a;
    bus_if.din = d;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0;
    bus_if.we = 1'b0;
  endtask

  task automatic bus_rd(input string tag, input logic [1:0] a, input logic [7:0] exp_v);
    bus_if.cs = 1'b1;
    bus_if.we = 1'b0;
    bus_if.rs = a;
    @(posedge clk);
    #1;
    bus_if.cs = 1'b0;
    chk(tag, bus_if.dout, exp_v);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst        = 1'b1;
    bus_if.cs  = 1'b0;
    bus_if.we  = 1'b0;
    bus_if.rs  = 2'd0;
    bus_if.din = 8'h00;
    cyc(3);
    rst = 1'b0;

    // Reset state
    chk("rst_dout", bus_if.dout, 8'h00);
    chk("rst_irq", {7'b0, bus_if.irq}, 8'h00);
    bus_rd("rst_ctrl", 2'd0, 8'h00);
    bus_rd("rst_stat", 2'd1, 8'h00);
    bus_rd("rst_cntl", 2'd2, 8'h00);
    bus_rd("rst_cnth", 2'd3, 8'h00);

    // Continuous mode, RELOAD=3 -> period 16 cycles; CTRL write edge is E0
    bus_wr(2'd2, 8'h03);
    bus_wr(2'd3, 8'h00);
    bus_wr(2'd0, 8'h03);
    cyc(15);
    chk("cont_pre1", {7'b0, bus_if.irq}, 8'h00);
    cyc(1);
    chk("cont_tf1", {7'b0, bus_if.irq}, 8'h01);
    bus_wr(2'd1, 8'h01);                       // E0+17
    chk("cont_w1c", {7'b0, bus_if.irq}, 8'h00);
    cyc(14);                                   // E0+31
    chk("cont_pre2", {7'b0, bus_if.irq}, 8'h00);
    cyc(1);                                    // E0+32
    chk("cont_tf2", {7'b0, bus_if.irq}, 8'h01);
    bus_rd("cont_stat", 2'd1, 8'h81);          // E0+33

    // Collision: W1C on terminal edge E0+48 -> TF stays set
    cyc(14);                                   // E0+47
    bus_wr(2'd1, 8'h01);                       // E0+48
    chk("coll_keep", {7'b0, bus_if.irq}, 8'h01);
    bus_wr(2'd1, 8'h01);                       // E0+49
    chk("coll_clear", {7'b0, bus_if.irq}, 8'h00);
    cyc(15);                                   // E0+64
    chk("cont_tf4", {7'b0, bus_if.irq}, 8'h01);

    // Reset mid-operation with irq high
    rst = 1'b1;
    cyc(1);
    chk("mid_rst_irq", {7'b0, bus_if.irq}, 8'h00);
    rst = 1'b0;
    bus_rd("mid_rst_ctrl", 2'd0, 8'h00);
    bus_rd("mid_rst_stat", 2'd1, 8'h00);
    bus_rd("mid_rst_cntl", 2'd2, 8'h00);
    bus_wr(2'd0, 8'h01);
    bus_rd("rst_reload_lo", 2'd2, 8'hFF);
    bus_rd("rst_reload_hi", 2'd3, 8'hFF);
    bus_wr(2'd0, 8'h00);

    // One-shot, RELOAD=2 -> TF at F0+12, EN auto-clears
    bus_wr(2'd2, 8'h02);
    bus_wr(2'd3, 8'h00);
    bus_wr(2'd0, 8'h05);                       // F0
    cyc(11);                                   // F0+11
    bus_rd("os_before", 2'd1, 8'h80);          // F0+12 (state after F0+11)
    bus_rd("os_after", 2'd1, 8'h01);           // F0+13
    bus_rd("os_ctrl", 2'd0, 8'h04);
    bus_rd("os_cntl", 2'd2, 8'h00);
    chk("os_irq", {7'b0, bus_if.irq}, 8'h00);
    cyc(10);
    bus_rd("os_cntl_hold", 2'd2, 8'h00);
    bus_rd("os_stat_hold", 2'd1, 8'h01);

    // RELOAD=0 -> timeout every PRESCALE cycles
    bus_wr(2'd1, 8'h01);
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd3, 8'h00);
    bus_wr(2'd0, 8'h03);                       // H0
    cyc(3);
    chk("r0_pre", {7'b0, bus_if.irq}, 8'h00);
    cyc(1);
    chk("r0_tf", {7'b0, bus_if.irq}, 8'h01);
    bus_wr(2'd0, 8'h00);
    bus_wr(2'd1, 8'h01);
    bus_rd("r0_stat_clr", 2'd1, 8'h00);

    // Coherent 16-bit read, RELOAD=0100
    bus_wr(2'd2, 8'h00);
    bus_wr(2'd3, 8'h01);
    bus_wr(2'd0, 8'h01);                       // G0, COUNT=0100
    bus_rd("coh_lo_100", 2'd2, 8'h00);         // G0+1, latch 01
    cyc(4);                                    // G0+5, COUNT=00FF
    bus_rd("coh_hi_100", 2'd3, 8'h01);         // G0+6
    bus_rd("coh_lo_0ff", 2'd2, 8'hFF);         // G0+7, latch 00
    bus_rd("coh_hi_0ff", 2'd3, 8'h00);         // G0+8, COUNT -> 00FE
    bus_wr(2'd0, 8'h00);                       // G0+9, freeze
    bus_rd("frz_lo1", 2'd2, 8'hFE);
    cyc(20);
    bus_rd("frz_lo2", 2'd2, 8'hFE);
    bus_rd("frz_stat", 2'd1, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
